// File: rtl/encoder_4x2_seq_if.sv
// Request/grant bundle for encoder_4x2_seq: requester drives x/e/rdy, encoder returns y/v/dup.
interface encoder_4x2_seq_if;
  logic [3:0] x;
  logic       e;
  logic       rdy;
  logic [1:0] y;
  logic       v;
  logic       dup;

  modport master (output x, e, rdy, input y, v, dup);
  modport slave  (input x, e, rdy, output y, v, dup);
endinterface

// File: rtl/encoder_4x2_seq.sv
// Sequential 4-to-2 request encoder with pending register and valid/ready output.
// Define ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority, bit 3 highest.
module encoder_4x2_seq (
  input  logic                 clk,
  input  logic                 rst_n,
  encoder_4x2_seq_if.slave     bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state;
  logic [3:0] p;
  logic [1:0] idx;
  logic       vld;
  logic       dup_pulse;

  logic [3:0] clr;
  logic [3:0] req_set;
  logic [3:0] rem;
  logic [1:0] pick_idle;
  logic [1:0] pick_hold;

  always_comb begin
    clr = 4'b0000;
    if (vld && bus.rdy) clr[idx] = 1'b1;
  end

  assign req_set = bus.x & {4{bus.e}};
  assign rem     = p & ~clr;

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr;

  // Search starts just after the last grant and wraps back to it last.
  function automatic logic [1:0] pick_rr(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] cand;
    pick_rr = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) pick_rr = cand;
    end
  endfunction

  assign pick_idle = pick_rr(p, ptr);
  assign pick_hold = pick_rr(rem, ptr);
`else
  function automatic logic [1:0] pick_fixed(input logic [3:0] req);
    if (req[3])      pick_fixed = 2'd3;
    else if (req[2]) pick_fixed = 2'd2;
    else if (req[1]) pick_fixed = 2'd1;
    else             pick_fixed = 2'd0;
  endfunction

  assign pick_idle = pick_fixed(p);
  assign pick_hold = pick_fixed(rem);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p         <= 4'b0000;
      idx       <= 2'b00;
      vld       <= 1'b0;
      dup_pulse <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr       <= 2'd3;
`endif
    end else begin
      // New requests win over the clear of the bit being served this edge.
      p         <= rem | req_set;
      dup_pulse <= |(req_set & rem);
      case (state)
        IDLE: begin
          if (p != 4'b0000) begin
            idx   <= pick_idle;
            vld   <= 1'b1;
            state <= HOLD;
`ifdef ROUND_ROBIN_EN
            ptr   <= pick_idle;
`endif
          end
        end
        HOLD: begin
          if (bus.rdy) begin
            if (rem != 4'b0000) begin
              idx <= pick_hold;
`ifdef ROUND_ROBIN_EN
              ptr <= pick_hold;
`endif
            end else begin
              vld   <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          vld   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.y   = idx;
  assign bus.v   = vld;
  assign bus.dup = dup_pulse;

endmodule

// File: doc/encoder_4x2_seq.md
ENCODER_4X2_SEQ -- requirements
Module: encoder_4x2_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port x  input  4  request lines, one per code 0..3; multi-hot allowed.
REQ-004 SHALL have port e  input  1  enable; x sampled only when e=1.
REQ-005 SHALL have port rdy  input  1  consumer ready.
REQ-006 SHALL have port y  output  2  encoded index of granted request.
REQ-007 SHALL have port v  output  1  y valid.
REQ-008 SHALL have port dup  output  1  one-cycle pulse: request on an already-pending bit.
REQ-009 SHALL use one clock; reset asynchronous, active-low, ports named clk and rst_n.

Function
REQ-010 SHALL hold a 4-bit pending register p; at each edge p <= (p & ~clr) | (x & {4{e}}), clr = one-hot of y when v&rdy, else 0.
REQ-011 SHALL give set priority over clear: request on bit being served in same cycle stays pending.
REQ-012 SHALL have FSM states IDLE (v=0) and HOLD (v=1), all outputs registered.
REQ-013 IDLE: if p!=0 at an edge, load y=selected index, go HOLD; else stay IDLE.
REQ-014 HOLD: y and v SHALL stay stable while rdy=0.
REQ-015 HOLD with rdy=1: if (p & ~clr)!=0, load next selected index into y, stay HOLD (back-to-back, no bubble); else go IDLE, v=0.
REQ-016 Selection in default build SHALL be fixed priority, bit 3 highest, bit 0 lowest.
REQ-017 Latency SHALL be 2 edges: x sampled at edge k with e=1 and no other pending -> v=1 after edge k+1.
REQ-018 dup SHALL pulse for exactly the cycle after an edge where x[i]&e=1 and p[i]=1 and bit i was not cleared that edge.
REQ-019 e=0 SHALL block new requests only; pending requests still drain.
REQ-020 y SHALL hold its last value in IDLE; y value meaningless when v=0.

Reset
REQ-021 rst_n=0 SHALL immediately clear p=0, y=2'b00, v=0, dup=0, FSM=IDLE, rr pointer=3, independent of clk.
REQ-022 Reset mid-HOLD SHALL drop v without waiting for an edge; all pending requests lost.
REQ-023 Operation SHALL resume on first rising clk edge after rst_n deasserts.

Configuration
REQ-024 Macro ROUND_ROBIN_EN SHALL select arbitration policy at compile time.
REQ-025 Without ROUND_ROBIN_EN: fixed priority per REQ-016; no pointer register.
REQ-026 With ROUND_ROBIN_EN: 2-bit pointer ptr = last granted index; search order ptr+1, ptr+2, ptr+3, ptr (mod 4); ptr updates on each load of y.
REQ-027 Ports, latency, handshake and dup behaviour SHALL be identical in both builds.

Verification
REQ-028 Reset, then x=4'b0100,e=1 one cycle, rdy=1 -> v=1,y=2'b10 two edges later for one cycle, then v=0.
REQ-029 x=4'b1111,e=1 one cycle, rdy=1 -> y sequence 11,10,01,00 on consecutive cycles, v continuous 4 cycles (default build).
REQ-030 x=4'b0010 pending, rdy=0 for 5 cycles -> y=01,v=1 stable; second x=4'b0010 during hold -> dup=1 one cycle.
REQ-031 x=4'b1000,e=0 -> v stays 0, p stays 0; p=4'b0001 pending then e=0 -> still granted y=00.
REQ-032 ROUND_ROBIN_EN, x=4'b1001 held with e=1, rdy=1 -> grants alternate 00,11,00,11 (ptr reset 3 -> first grant 00).
REQ-033 rst_n=0 asserted mid-HOLD between edges -> v=0 immediately; after release with x=0 -> v stays 0.
